uart_tx_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one UART transmitter among NUM_REQ parallel-data requesters.
- Grants one requester and latches its byte, then issues a one-cycle DATA_VALID to the Tx. It tracks the Tx Busy flag through the whole frame and acknowledges the requester when the frame finishes.
- Sits between the system-side producers (register file, FIFOs, debug port) and the UART Tx top (FSM + serializer + parity + mux).

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 21 ++
 rtl/uart_tx_arbiter.sv | 100 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, arbiter state encoding and ID width helper
package uart_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  typedef logic [2:0] arb_state_t;
  localparam arb_state_t S_IDLE      = 3'd0;
  localparam arb_state_t S_LOAD      = 3'd1;
  localparam arb_state_t S_WAIT_BUSY = 3'd2;
  localparam arb_state_t S_WAIT_DONE = 3'd3;
  localparam arb_state_t S_DONE      = 3'd4;
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or above i_ptr with wrap
import uart_pkg::*;
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = id_width(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx
);
  logic [N-1:0] w_rot;
  assign w_rot = N'({i_req, i_req} >> i_ptr);
  // lowest rotated offset wins; scanning downward lets the nearest one overwrite
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (w_rot[k]) o_idx = W'((int'(i_ptr) + k) % N);
  end
  assign o_gnt = |i_req ? (N'(1) << o_idx) : '0;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sequencer sharing one UART Tx among NUM_REQ requesters.
// Define UART_TX_ARB_TIMEOUT_EN to build the TX_BUSY watchdog and sticky o_timeout_err.
import uart_pkg::*;
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [NUM_REQ-1:0]                  i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]                  o_ack,
  output logic [id_width(NUM_REQ)-1:0]        o_gnt_id,
  output logic                                o_arb_busy,
  output logic [DATA_WIDTH-1:0]               o_tx_p_data,
  output logic                                o_tx_data_valid,
  input  logic                                i_tx_busy,
  output logic                                o_timeout_err
);
  localparam int IW = id_width(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end
  arb_state_t            r_state;
  logic [IW-1:0]         r_ptr, r_gnt_id, w_idx;
  logic [NUM_REQ-1:0]    r_gnt_oh, r_ack, w_gnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_busy, r_valid, w_timeout;
  rr_arbiter #(.N(NUM_REQ), .W(IW)) u_rr (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_terr;
  assign w_timeout = (r_state == S_WAIT_BUSY) && !i_tx_busy && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  // counts cycles spent waiting for the Tx to take the strobe
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else r_cnt <= (r_state == S_WAIT_BUSY) ? r_cnt + 1'b1 : '0;
  // error flag sticks until reset
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_terr <= 1'b0;
    else if (w_timeout) r_terr <= 1'b1;
  assign o_timeout_err = r_terr;
`else
  assign w_timeout     = 1'b0;
  assign o_timeout_err = 1'b0;
`endif
  // grant, strobe and frame-tracking state machine; byte is held from grant until the next grant
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_gnt_id <= '0;
      r_gnt_oh <= '0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_ack    <= '0;
    end else begin
      r_valid <= 1'b0;
      r_ack   <= '0;
      case (r_state)
        S_IDLE: if (|i_req) begin
          r_data   <= i_req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
          r_gnt_id <= w_idx;
          r_gnt_oh <= w_gnt;
          r_busy   <= 1'b1;
          r_valid  <= 1'b1;
          r_state  <= S_LOAD;
        end
        S_LOAD: r_state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (i_tx_busy) r_state <= S_WAIT_DONE;
        else if (w_timeout) begin
          r_ack   <= r_gnt_oh;
          r_state <= S_DONE;
        end
        S_WAIT_DONE: if (!i_tx_busy) begin
          r_ack   <= r_gnt_oh;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_ptr   <= (r_gnt_id == IW'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  assign o_ack           = r_ack;
  assign o_gnt_id        = r_gnt_id;
  assign o_arb_busy      = r_busy;
  assign o_tx_p_data     = r_data;
  assign o_tx_data_valid = r_valid;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with frame/ack scoreboards and a behavioural Tx model
module tb_uart_tx_arbiter;
  localparam int FRAME = 11;
  logic        clk, rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  gnt_id;
  logic        arb_busy, tx_valid, terr;
  logic [7:0]  tx_p_data;
  logic        model_busy, ext_busy, tx_mute;
  wire         tx_busy = model_busy | ext_busy;
  int          n_tests = 0, n_fail = 0;
  logic [9:0]  fq[$];
  logic [3:0]  aq[$];
  logic [9:0]  fe;
  logic [3:0]  ae;

  uart_tx_arbiter dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req           (req),
    .i_req_data      (req_data),
    .o_ack           (ack),
    .o_gnt_id        (gnt_id),
    .o_arb_busy      (arb_busy),
    .o_tx_p_data     (tx_p_data),
    .o_tx_data_valid (tx_valid),
    .i_tx_busy       (tx_busy),
    .o_timeout_err   (terr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Tx model: Busy rises right after the strobe and holds for FRAME cycles
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid && !tx_mute) begin
        model_busy = 1'b1;
        repeat (FRAME) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  // monitor: pops expected frames on each strobe and expected acks on each ack pulse
  always @(negedge clk) begin
    if (tx_valid) begin
      if (fq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL frame_unexpected: got id %0d data %0h, required no frame", gnt_id, tx_p_data);
      end else begin
        fe = fq.pop_front();
        chk("frame_id", 32'(gnt_id), 32'(fe[9:8]));
        chk("frame_data", 32'(tx_p_data), 32'(fe[7:0]));
      end
    end
    if (ack != 4'b0) begin
      if (aq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL ack_unexpected: got %b, required no ack", ack);
      end else begin
        ae = aq.pop_front();
        chk("ack", 32'(ack), 32'(ae));
      end
    end
  end

  task automatic exp_frame(input logic [1:0] id, input logic [7:0] d);
    fq.push_back({id, d});
    aq.push_back(4'b1 << id);
  endtask

  task automatic wait_ack(input int limit);
    int n = 0;
    @(negedge clk);
    while (ack == 4'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (ack == 4'b0) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: got no ack within %0d cycles, required an ack", limit);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0; ext_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = 4'b0; req_data = 32'h0; ext_busy = 1'b0; tx_mute = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_arb_busy", 32'(arb_busy), 0);
    chk("rst_tx_p_data", 32'(tx_p_data), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_timeout_err", 32'(terr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single request from requester 1
    req_data = 32'h0000_A500;
    exp_frame(2'd1, 8'hA5);
    req = 4'b0010;
    @(negedge clk);
    chk("lat_valid", 32'(tx_valid), 1);
    chk("lat_arb_busy", 32'(arb_busy), 1);
    wait_ack(60);
    req = req & ~ack;
    @(negedge clk);
    chk("single_busy_drop", 32'(arb_busy), 0);

    // simultaneous requests from reset: 0,1,2,3
    do_reset();
    req_data = 32'h4433_2211;
    exp_frame(2'd0, 8'h11); exp_frame(2'd1, 8'h22);
    exp_frame(2'd2, 8'h33); exp_frame(2'd3, 8'h44);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(60);
      req = req & ~ack;
    end
    repeat (3) @(negedge clk);
    chk("all_idle", 32'(arb_busy), 0);

    // fairness with 0 and 2 held high: 0,2,0,2
    req_data = 32'h00C2_00A0;
    exp_frame(2'd0, 8'hA0); exp_frame(2'd2, 8'hC2);
    exp_frame(2'd0, 8'hA0); exp_frame(2'd2, 8'hC2);
    req = 4'b0101;
    for (int i = 0; i < 4; i++) wait_ack(60);
    req = 4'b0;

    // requester 1 drops its request mid-frame
    req_data = 32'h0000_B700;
    exp_frame(2'd1, 8'hB7);
    req = 4'b0010;
    for (int i = 0; i < 20 && !tx_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    req = 4'b0;
    wait_ack(60);
    repeat (20) @(negedge clk);
    chk("drop_no_regrant", 32'(arb_busy), 0);

    // reset in the middle of a frame
    req_data = 32'h5D00_0000;
    fq.push_back({2'd3, 8'h5D});
    req = 4'b1000;
    for (int i = 0; i < 20 && !tx_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ack", 32'(ack), 0);
    chk("abort_gnt_id", 32'(gnt_id), 0);
    chk("abort_arb_busy", 32'(arb_busy), 0);
    chk("abort_tx_p_data", 32'(tx_p_data), 0);
    chk("abort_tx_valid", 32'(tx_valid), 0);
    req = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + 4) @(negedge clk);
    req_data = 32'h0066_5500;
    exp_frame(2'd1, 8'h55); exp_frame(2'd2, 8'h66);
    req = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      wait_ack(60);
      req = req & ~ack;
    end

    // Tx already busy from a foreign source when the strobe goes out
    tx_mute = 1'b1;
    ext_busy = 1'b1;
    req_data = 32'h0000_003C;
    exp_frame(2'd0, 8'h3C);
    req = 4'b0001;
    repeat (8) begin
      @(negedge clk);
      chk("foreign_hold_ack", 32'(ack), 0);
    end
    ext_busy = 1'b0;
    wait_ack(10);
    req = 4'b0;
    @(negedge clk);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Tx never answers: watchdog aborts the frame
    req_data = 32'h0000_007E;
    exp_frame(2'd0, 8'h7E);
    req = 4'b0001;
    wait_ack(40);
    req = 4'b0;
    chk("timeout_err_set", 32'(terr), 1);
    repeat (5) @(negedge clk);
    chk("timeout_err_sticky", 32'(terr), 1);
    chk("timeout_idle", 32'(arb_busy), 0);
    do_reset();
    chk("timeout_err_cleared", 32'(terr), 0);
`else
    // Tx never answers: arbiter waits until Busy finally shows up
    req_data = 32'h0000_007E;
    fq.push_back({2'd0, 8'h7E});
    req = 4'b0001;
    repeat (40) @(negedge clk);
    chk("no_timeout_busy", 32'(arb_busy), 1);
    chk("no_timeout_err", 32'(terr), 0);
    aq.push_back(4'b0001);
    ext_busy = 1'b1;
    repeat (2) @(negedge clk);
    ext_busy = 1'b0;
    wait_ack(10);
    req = 4'b0;
`endif
    repeat (5) @(negedge clk);
    chk("frame_queue_empty", 32'(fq.size()), 0);
    chk("ack_queue_empty", 32'(aq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
